// File: rtl/vga_timing_pkg.sv
// Default 640x480@60 raster geometry, derived line/frame totals and datapath widths.
// Shared by the timing generator, its axis counters and the output interface.
package vga_timing_pkg;

  localparam int unsigned H_ACTIVE_DEF = 640;
  localparam int unsigned H_FP_DEF     = 16;
  localparam int unsigned H_SYNC_DEF   = 96;
  localparam int unsigned H_BP_DEF     = 48;

  localparam int unsigned V_ACTIVE_DEF = 480;
  localparam int unsigned V_FP_DEF     = 10;
  localparam int unsigned V_SYNC_DEF   = 2;
  localparam int unsigned V_BP_DEF     = 33;

  localparam int unsigned CNT_W   = 10;
  localparam int unsigned COORD_W = 9;

  function automatic int unsigned axis_total(input int unsigned act, input int unsigned fp,
                                             input int unsigned sync, input int unsigned bp);
    return act + fp + sync + bp;
  endfunction

  localparam int unsigned H_TOTAL = axis_total(H_ACTIVE_DEF, H_FP_DEF, H_SYNC_DEF, H_BP_DEF);
  localparam int unsigned V_TOTAL = axis_total(V_ACTIVE_DEF, V_FP_DEF, V_SYNC_DEF, V_BP_DEF);

endpackage

// File: rtl/vga_timing_gen_if.sv
// Raster timing bundle from the generator to pixel sources and the connector pins.
// Strobe signals exist only when VGA_FRAME_STROBE_EN is defined.
interface vga_timing_gen_if
  import vga_timing_pkg::*;
  ();

  logic [COORD_W-1:0] pos_x;
  logic [COORD_W-1:0] pos_y;
  logic               active;
  logic               o_hsync;
  logic               o_vsync;
`ifdef VGA_FRAME_STROBE_EN
  logic               o_line_start;
  logic               o_frame_start;
`endif

  modport master (
    output pos_x, pos_y, active, o_hsync, o_vsync
`ifdef VGA_FRAME_STROBE_EN
    , output o_line_start, o_frame_start
`endif
  );

  modport slave (
    input pos_x, pos_y, active, o_hsync, o_vsync
`ifdef VGA_FRAME_STROBE_EN
    , input o_line_start, o_frame_start
`endif
  );

endinterface

// File: rtl/vga_axis_counter.sv
// One raster axis: wrapping position counter with sync-window and active-window decode.
// Latency: count registered, decode flags combinational from the current count.
// Backpressure: none; advances on every enabled clock.
module vga_axis_counter
  import vga_timing_pkg::*;
#(
  parameter int unsigned ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned FP     = H_FP_DEF,
  parameter int unsigned SYNC   = H_SYNC_DEF,
  parameter int unsigned BP     = H_BP_DEF
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic             i_en,
  output logic [CNT_W-1:0] o_cnt,
  output logic             o_wrap,
  output logic             o_sync_win,
  output logic             o_active_win
);

  localparam int unsigned      TOTAL     = axis_total(ACTIVE, FP, SYNC, BP);
  localparam logic [CNT_W-1:0] L_LAST    = CNT_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0] L_ACT     = CNT_W'(ACTIVE);
  localparam logic [CNT_W-1:0] L_SYNC_LO = CNT_W'(ACTIVE + FP);
  localparam logic [CNT_W-1:0] L_SYNC_HI = CNT_W'(ACTIVE + FP + SYNC - 1);

  logic [CNT_W-1:0] r_cnt;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_cnt <= '0;
    end else if (i_en) begin
      r_cnt <= o_wrap ? '0 : r_cnt + 1'b1;
    end
  end

  assign o_cnt        = r_cnt;
  assign o_wrap       = (r_cnt == L_LAST);
  assign o_sync_win   = (r_cnt >= L_SYNC_LO) && (r_cnt <= L_SYNC_HI);
  assign o_active_win = (r_cnt < L_ACT);

endmodule

// File: rtl/vga_timing_gen.sv
// VGA raster timing generator with pixel-doubled coordinates; VGA_FRAME_STROBE_EN adds line/frame strobes.
// Latency: every output registered, one clock behind the counter state it decodes.
// Backpressure: none; free-running on every clock outside reset.
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = H_ACTIVE_DEF,
  parameter int unsigned H_FP     = H_FP_DEF,
  parameter int unsigned H_SYNC   = H_SYNC_DEF,
  parameter int unsigned H_BP     = H_BP_DEF,
  parameter int unsigned V_ACTIVE = V_ACTIVE_DEF,
  parameter int unsigned V_FP     = V_FP_DEF,
  parameter int unsigned V_SYNC   = V_SYNC_DEF,
  parameter int unsigned V_BP     = V_BP_DEF,
  parameter bit          SYNC_POL = 1'b0
) (
  input  logic             clk25MHz,
  input  logic             rst_n,
  vga_timing_gen_if.master vga
);

  logic [CNT_W-1:0] w_h_cnt;
  logic [CNT_W-1:0] w_v_cnt;
  logic             w_h_wrap;
  logic             w_v_wrap;
  logic             w_h_sync;
  logic             w_v_sync;
  logic             w_h_act;
  logic             w_v_act;
  logic             w_active;
  logic             w_unused;

  vga_axis_counter #(
    .ACTIVE(H_ACTIVE), .FP(H_FP), .SYNC(H_SYNC), .BP(H_BP)
  ) u_h_axis (
    .i_clk       (clk25MHz),
    .i_rst_n     (rst_n),
    .i_en        (1'b1),
    .o_cnt       (w_h_cnt),
    .o_wrap      (w_h_wrap),
    .o_sync_win  (w_h_sync),
    .o_active_win(w_h_act)
  );

  // Vertical axis steps once per line, on the horizontal wrap.
  vga_axis_counter #(
    .ACTIVE(V_ACTIVE), .FP(V_FP), .SYNC(V_SYNC), .BP(V_BP)
  ) u_v_axis (
    .i_clk       (clk25MHz),
    .i_rst_n     (rst_n),
    .i_en        (w_h_wrap),
    .o_cnt       (w_v_cnt),
    .o_wrap      (w_v_wrap),
    .o_sync_win  (w_v_sync),
    .o_active_win(w_v_act)
  );

  assign w_active = w_h_act && w_v_act;
  assign w_unused = w_v_wrap;

  logic [COORD_W-1:0] r_pos_x;
  logic [COORD_W-1:0] r_pos_y;
  logic               r_active;
  logic               r_hsync;
  logic               r_vsync;

  // Coordinates are zeroed in blanking so consumers never see stale positions.
  always_ff @(posedge clk25MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_pos_x  <= '0;
      r_pos_y  <= '0;
      r_active <= 1'b0;
      r_hsync  <= ~SYNC_POL;
      r_vsync  <= ~SYNC_POL;
    end else begin
      r_pos_x  <= w_active ? COORD_W'(w_h_cnt >> 1) : '0;
      r_pos_y  <= w_active ? COORD_W'(w_v_cnt >> 1) : '0;
      r_active <= w_active;
      r_hsync  <= w_h_sync ? SYNC_POL : ~SYNC_POL;
      r_vsync  <= w_v_sync ? SYNC_POL : ~SYNC_POL;
    end
  end

  assign vga.pos_x   = r_pos_x;
  assign vga.pos_y   = r_pos_y;
  assign vga.active  = r_active;
  assign vga.o_hsync = r_hsync;
  assign vga.o_vsync = r_vsync;

`ifdef VGA_FRAME_STROBE_EN
  logic r_line_start;
  logic r_frame_start;

  always_ff @(posedge clk25MHz or negedge rst_n) begin
    if (!rst_n) begin
      r_line_start  <= 1'b0;
      r_frame_start <= 1'b0;
    end else begin
      r_line_start  <= (w_h_cnt == '0) && w_v_act;
      r_frame_start <= (w_h_cnt == '0) && (w_v_cnt == '0);
    end
  end

  assign vga.o_line_start  = r_line_start;
  assign vga.o_frame_start = r_frame_start;
`endif

endmodule

// File: tb/tb_vga_timing_gen.sv
// Directed bench: full-size generator for reset and line timing, a shrunken
// active-high-sync instance (48x30 totals) for whole-frame behaviour.
module tb_vga_timing_gen;
  import vga_timing_pkg::*;

  logic clk25MHz = 1'b0;
  logic rst_n    = 1'b0;
  logic rst_s_n  = 1'b0;
  int   n_cmp    = 0;
  int   n_bad    = 0;
  int   e        = 0;

  always #20 clk25MHz = ~clk25MHz;

  vga_timing_gen_if vd ();
  vga_timing_gen_if vs ();

  vga_timing_gen dut (
    .clk25MHz(clk25MHz),
    .rst_n   (rst_n),
    .vga     (vd)
  );

  vga_timing_gen #(
    .H_ACTIVE(32), .H_FP(4), .H_SYNC(8), .H_BP(4),
    .V_ACTIVE(20), .V_FP(3), .V_SYNC(2), .V_BP(5),
    .SYNC_POL(1'b1)
  ) sdut (
    .clk25MHz(clk25MHz),
    .rst_n   (rst_s_n),
    .vga     (vs)
  );

  task automatic tick;
    @(posedge clk25MHz);
    #1;
    e++;
  endtask

  task automatic test_reset;
    rst_n   = 1'b0;
    rst_s_n = 1'b0;
    repeat (10) tick();
    n_cmp++; if (vd.active !== 1'b0) begin n_bad++; $display("FAIL rst_active got %0b want 0", vd.active); end
    n_cmp++; if (vd.pos_x !== 9'd0) begin n_bad++; $display("FAIL rst_pos_x got %0d want 0", vd.pos_x); end
    n_cmp++; if (vd.pos_y !== 9'd0) begin n_bad++; $display("FAIL rst_pos_y got %0d want 0", vd.pos_y); end
    n_cmp++; if (vd.o_hsync !== 1'b1) begin n_bad++; $display("FAIL rst_hsync got %0b want 1", vd.o_hsync); end
    n_cmp++; if (vd.o_vsync !== 1'b1) begin n_bad++; $display("FAIL rst_vsync got %0b want 1", vd.o_vsync); end
    n_cmp++; if (vs.o_hsync !== 1'b0) begin n_bad++; $display("FAIL rst_hsync_pol1 got %0b want 0", vs.o_hsync); end
    n_cmp++; if (vs.o_vsync !== 1'b0) begin n_bad++; $display("FAIL rst_vsync_pol1 got %0b want 0", vs.o_vsync); end
`ifdef VGA_FRAME_STROBE_EN
    n_cmp++; if (vd.o_line_start !== 1'b0) begin n_bad++; $display("FAIL rst_line_start got %0b want 0", vd.o_line_start); end
    n_cmp++; if (vd.o_frame_start !== 1'b0) begin n_bad++; $display("FAIL rst_frame_start got %0b want 0", vd.o_frame_start); end
`endif
  endtask

  task automatic test_first_line;
    @(negedge clk25MHz);
    rst_n = 1'b1;
    e = 0;
    tick();
    n_cmp++; if (vd.active !== 1'b1) begin n_bad++; $display("FAIL edge1_active got %0b want 1", vd.active); end
    n_cmp++; if (vd.pos_x !== 9'd0 || vd.pos_y !== 9'd0) begin n_bad++; $display("FAIL edge1_pos got (%0d,%0d) want (0,0)", vd.pos_x, vd.pos_y); end
`ifdef VGA_FRAME_STROBE_EN
    n_cmp++; if (vd.o_frame_start !== 1'b1) begin n_bad++; $display("FAIL edge1_frame_start got %0b want 1", vd.o_frame_start); end
`endif
    tick();
    n_cmp++; if (vd.pos_x !== 9'd0) begin n_bad++; $display("FAIL edge2_pos_x got %0d want 0", vd.pos_x); end
`ifdef VGA_FRAME_STROBE_EN
    n_cmp++; if (vd.o_frame_start !== 1'b0) begin n_bad++; $display("FAIL edge2_frame_start got %0b want 0", vd.o_frame_start); end
`endif
    tick();
    n_cmp++; if (vd.pos_x !== 9'd1) begin n_bad++; $display("FAIL edge3_pos_x got %0d want 1", vd.pos_x); end
    while (e < 640) tick();
    n_cmp++; if (vd.active !== 1'b1 || vd.pos_x !== 9'd319) begin n_bad++; $display("FAIL edge640 got active=%0b x=%0d want 1,319", vd.active, vd.pos_x); end
    tick();
    n_cmp++; if (vd.active !== 1'b0 || vd.pos_x !== 9'd0) begin n_bad++; $display("FAIL edge641 got active=%0b x=%0d want 0,0", vd.active, vd.pos_x); end
  endtask

  task automatic test_line_sync;
    int first_low  = -1;
    int second_low = -1;
    int low_cnt    = 0;
    int blank_nz   = 0;
    int vs_low     = 0;
    $display("default geometry totals %0d x %0d", H_TOTAL, V_TOTAL);
    while (e < 2 * H_TOTAL + 100) begin
      tick();
      if (vd.o_hsync === 1'b0) begin
        if (e <= 800) begin
          low_cnt++;
          if (first_low < 0) first_low = e;
        end else if (second_low < 0) begin
          second_low = e;
        end
      end
      if (e <= 800 && vd.pos_x !== 9'd0) blank_nz++;
      if (vd.o_vsync !== 1'b1) vs_low++;
      if (e == 801) begin
        n_cmp++; if (vd.active !== 1'b1 || vd.pos_x !== 9'd0) begin n_bad++; $display("FAIL line1_start got active=%0b x=%0d want 1,0", vd.active, vd.pos_x); end
`ifdef VGA_FRAME_STROBE_EN
        n_cmp++; if (vd.o_line_start !== 1'b1 || vd.o_frame_start !== 1'b0) begin n_bad++; $display("FAIL line1_strobes got ls=%0b fs=%0b want 1,0", vd.o_line_start, vd.o_frame_start); end
`endif
      end
    end
    n_cmp++; if (first_low != 657) begin n_bad++; $display("FAIL hsync_start got %0d want 657", first_low); end
    n_cmp++; if (low_cnt != 96) begin n_bad++; $display("FAIL hsync_width got %0d want 96", low_cnt); end
    n_cmp++; if (second_low - first_low != 800) begin n_bad++; $display("FAIL line_period got %0d want 800", second_low - first_low); end
    n_cmp++; if (blank_nz != 0) begin n_bad++; $display("FAIL blank_pos_x got %0d nonzero want 0", blank_nz); end
    n_cmp++; if (vs_low != 0) begin n_bad++; $display("FAIL early_vsync got %0d asserted want 0", vs_low); end
  endtask

  task automatic test_mid_frame_reset;
    while (e < 1900) tick();
    n_cmp++; if (vd.active !== 1'b1 || vd.pos_x !== 9'd149 || vd.pos_y !== 9'd1) begin n_bad++; $display("FAIL pre_reset got a=%0b (%0d,%0d) want 1 (149,1)", vd.active, vd.pos_x, vd.pos_y); end
    #5;
    rst_n = 1'b0;
    #2;
    n_cmp++; if (vd.active !== 1'b0 || vd.pos_x !== 9'd0 || vd.pos_y !== 9'd0) begin n_bad++; $display("FAIL async_reset got a=%0b (%0d,%0d) want 0 (0,0)", vd.active, vd.pos_x, vd.pos_y); end
    repeat (2) tick();
    @(negedge clk25MHz);
    rst_n = 1'b1;
    e = 0;
    tick();
    n_cmp++; if (vd.active !== 1'b1 || vd.pos_x !== 9'd0 || vd.pos_y !== 9'd0) begin n_bad++; $display("FAIL restart got a=%0b (%0d,%0d) want 1 (0,0)", vd.active, vd.pos_x, vd.pos_y); end
    tick();
    tick();
    n_cmp++; if (vd.pos_x !== 9'd1) begin n_bad++; $display("FAIL restart_x got %0d want 1", vd.pos_x); end
  endtask

  task automatic test_small_frame;
    int hs_first = -1;
    int hs_cnt   = 0;
    int vs_first = -1;
    int vs_cnt   = 0;
    int act_cnt  = 0;
    int blank_a  = 0;
    int max_x    = 0;
    int max_y    = 0;
    int y_line19 = -1;
`ifdef VGA_FRAME_STROBE_EN
    int fs_cnt   = 0;
    int ls_cnt   = 0;
    int ls_blank = 0;
`endif
    @(negedge clk25MHz);
    rst_s_n = 1'b1;
    e = 0;
    while (e < 1440) begin
      tick();
      if (vs.o_hsync === 1'b1 && e <= 48) begin
        hs_cnt++;
        if (hs_first < 0) hs_first = e;
      end
      if (vs.o_vsync === 1'b1) begin
        vs_cnt++;
        if (vs_first < 0) vs_first = e;
      end
      if (vs.active === 1'b1) act_cnt++;
      if (e > 960 && vs.active !== 1'b0) blank_a++;
      if (int'(vs.pos_x) > max_x) max_x = int'(vs.pos_x);
      if (int'(vs.pos_y) > max_y) max_y = int'(vs.pos_y);
      if (e == 913) y_line19 = int'(vs.pos_y);
`ifdef VGA_FRAME_STROBE_EN
      if (vs.o_frame_start === 1'b1) fs_cnt++;
      if (vs.o_line_start === 1'b1) ls_cnt++;
      if (e > 960 && vs.o_line_start !== 1'b0) ls_blank++;
`endif
    end
    n_cmp++; if (hs_first != 37 || hs_cnt != 8) begin n_bad++; $display("FAIL s_hsync got start=%0d width=%0d want 37,8", hs_first, hs_cnt); end
    n_cmp++; if (vs_first != 1105) begin n_bad++; $display("FAIL s_vsync_start got %0d want 1105", vs_first); end
    n_cmp++; if (vs_cnt != 96) begin n_bad++; $display("FAIL s_vsync_width got %0d want 96", vs_cnt); end
    n_cmp++; if (act_cnt != 640) begin n_bad++; $display("FAIL s_active_count got %0d want 640", act_cnt); end
    n_cmp++; if (blank_a != 0) begin n_bad++; $display("FAIL s_active_in_vblank got %0d want 0", blank_a); end
    n_cmp++; if (max_x != 15 || max_y != 9) begin n_bad++; $display("FAIL s_max_pos got (%0d,%0d) want (15,9)", max_x, max_y); end
    n_cmp++; if (y_line19 != 9) begin n_bad++; $display("FAIL s_pos_y_line19 got %0d want 9", y_line19); end
    tick();
    n_cmp++; if (vs.active !== 1'b1 || vs.pos_x !== 9'd0 || vs.pos_y !== 9'd0) begin n_bad++; $display("FAIL s_frame_period got a=%0b (%0d,%0d) want 1 (0,0)", vs.active, vs.pos_x, vs.pos_y); end
`ifdef VGA_FRAME_STROBE_EN
    n_cmp++; if (vs.o_frame_start !== 1'b1) begin n_bad++; $display("FAIL s_frame_start_again got %0b want 1", vs.o_frame_start); end
    n_cmp++; if (fs_cnt != 1) begin n_bad++; $display("FAIL s_frame_start_count got %0d want 1", fs_cnt); end
    n_cmp++; if (ls_cnt != 20) begin n_bad++; $display("FAIL s_line_start_count got %0d want 20", ls_cnt); end
    n_cmp++; if (ls_blank != 0) begin n_bad++; $display("FAIL s_line_start_vblank got %0d want 0", ls_blank); end
`endif
  endtask

  task automatic test_small_mid_reset;
    // Edge 1958 decodes h=37,v=10: inside the horizontal sync window.
    while (e < 1958) tick();
    n_cmp++; if (vs.o_hsync !== 1'b1 || vs.active !== 1'b0) begin n_bad++; $display("FAIL s_pre_reset got hs=%0b a=%0b want 1,0", vs.o_hsync, vs.active); end
    #5;
    rst_s_n = 1'b0;
    #2;
    n_cmp++; if (vs.o_hsync !== 1'b0 || vs.o_vsync !== 1'b0) begin n_bad++; $display("FAIL s_async_reset got hs=%0b vs=%0b want 0,0", vs.o_hsync, vs.o_vsync); end
    repeat (2) tick();
    @(negedge clk25MHz);
    rst_s_n = 1'b1;
    e = 0;
    tick();
    n_cmp++; if (vs.active !== 1'b1 || vs.pos_x !== 9'd0 || vs.pos_y !== 9'd0) begin n_bad++; $display("FAIL s_restart got a=%0b (%0d,%0d) want 1 (0,0)", vs.active, vs.pos_x, vs.pos_y); end
  endtask

  initial begin
    test_reset();
    test_first_line();
    test_line_sync();
    test_mid_frame_reset();
    test_small_frame();
    test_small_mid_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
